mem_bus_interface: RTL

Receiving end of the datapath bus: latches bus values into MAR/MDR and runs SRAM read/write cycles on their behalf. Generates active-low SRAM strobes with a fixed, parameterised wait-state count and a one-cycle ready pulse (R) for the control FSM. MDR loads either from the bus (CPU store path) or from SRAM read data (load path). Sits between the bus driver, the control unit and the external SRAM.

---
 rtl/mem_bus_interface.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_bus_interface.sv
// Bus-side memory interface: MAR/MDR registers plus an SRAM access sequencer
// that drives active-low strobes for WAIT_CYCLES cycles and then pulses R.
module mem_bus_interface #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] BUS,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MIO_EN,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic        R
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;

    logic in_access;
    logic write_access;

    assign in_access    = (state_q == ACCESS);
    assign write_access = in_access && we_q;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (MEM_REQ) begin
                    state_d = ACCESS;
                    we_d    = MEM_WE;
                    cnt_d   = CNT_INIT;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address and write data must stay stable while the SRAM is strobed.
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        if (LD_MAR && !in_access) begin
            mar_d = BUS;
        end
        if (LD_MDR && !write_access) begin
            mdr_d = MIO_EN ? Data_from_SRAM : BUS;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    // Strobes decode from registered state only, keeping them glitch-free w.r.t. inputs.
    assign CE_N         = !in_access;
    assign OE_N         = !(in_access && !we_q);
    assign WE_N         = !write_access;
    assign R            = (state_q == DONE);
    assign MAR          = mar_q;
    assign ADDR         = mar_q;
    assign MDR          = mdr_q;
    assign Data_to_SRAM = mdr_q;

endmodule
